// File: rtl/note_lane_engine.sv
// Falling-note playfield: song row memory, scroll/row FSM, windowed hit scoring
// and registered per-lane pixel-on flags for the VGA colour path.
module note_lane_engine #(
  parameter int unsigned LANES    = 3,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned LANE_W   = 200,
  parameter int unsigned LANE_GAP = 20,
  parameter int unsigned BAR_H    = 10,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned SPEED    = 1,
  parameter int unsigned HIT_Y    = 400,
  parameter int unsigned HIT_WIN  = 16,
  parameter int unsigned SCORE_W  = 8,
  localparam int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic [LANES-1:0]   btn,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [LANES-1:0]   wr_data,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  output logic [LANES-1:0]   lane_on,
  output logic [9:0]         pos,
  output logic [ADDR_W-1:0]  row,
  output logic [SCORE_W-1:0] hits,
  output logic [SCORE_W-1:0] misses,
  output logic [1:0]         state,
  output logic               done
);

  localparam int unsigned MEM_N = 1 << ADDR_W;
  localparam int unsigned CNT_W = SCORE_W + 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DONE = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [9:0]          pos_d;
  logic [ADDR_W-1:0]   row_d;
  logic [SCORE_W-1:0]  hits_d, misses_d;
  logic [LANES-1:0]    live_q, live_d;
  logic [LANES-1:0]    hit_vec, miss_vec;
  logic [LANES-1:0]    in_lane, lane_on_d;
  logic [10:0]         pos_nx;
  logic                in_win, y_hit;

  logic [LANES-1:0]    mem [MEM_N];

  function automatic logic [3:0] popcount(input logic [LANES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < LANES; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [3:0] n);
    logic [CNT_W-1:0] s;
    s = CNT_W'(a) + CNT_W'(n);
    return (s > CNT_W'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(s);
  endfunction

  // Song memory is not reset so a loaded song survives a game reset.
  always_ff @(posedge clk) begin
    if (wr_en && state_q != ST_PLAY) mem[wr_addr] <= wr_data;
  end

  assign in_win = (11'(pos) + 11'(HIT_WIN) >= 11'(HIT_Y)) &&
                  (11'(pos) <= 11'(HIT_Y + HIT_WIN));
  assign y_hit  = (11'(pix_y) + 11'(BAR_H) >= 11'(pos)) &&
                  (11'(pix_y) <= 11'(pos) + 11'(BAR_H));

  // Unsigned wrap makes x below the lane start fail the width test too.
  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    localparam int unsigned LO = i * (LANE_W + LANE_GAP);
    assign in_lane[i] = (32'(pix_x) - LO) < LANE_W;
  end

  assign lane_on_d = (state_q == ST_PLAY && y_hit) ? (live_q & in_lane) : '0;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos;
    row_d    = row;
    hits_d   = hits;
    misses_d = misses;
    live_d   = live_q;
    hit_vec  = '0;
    miss_vec = '0;
    pos_nx   = 11'(pos) + 11'(SPEED);
    case (state_q)
      ST_PLAY: begin
        hit_vec  = btn & live_q & {LANES{in_win}};
        miss_vec = btn & ~hit_vec;
        hits_d   = sat_add(hits, popcount(hit_vec));
        misses_d = sat_add(misses, popcount(miss_vec));
        live_d   = live_q & ~hit_vec;
        // A row reload overrides any live clear made this cycle.
        if (tick) begin
          if (pos_nx < 11'(SCREEN_H)) begin
            pos_d = pos_nx[9:0];
          end else if (row == ADDR_W'(DEPTH - 1)) begin
            state_d = ST_DONE;
          end else begin
            row_d  = row + 1'b1;
            pos_d  = '0;
            live_d = mem[row_d];
          end
        end
      end
      default: begin
        if (start) begin
          state_d  = ST_PLAY;
          row_d    = '0;
          pos_d    = '0;
          hits_d   = '0;
          misses_d = '0;
          live_d   = mem[0];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pos     <= '0;
      row     <= '0;
      hits    <= '0;
      misses  <= '0;
      live_q  <= '0;
      lane_on <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pos     <= pos_d;
      row     <= row_d;
      hits    <= hits_d;
      misses  <= misses_d;
      live_q  <= live_d;
      lane_on <= lane_on_d;
      done    <= (state_d == ST_DONE);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_note_lane_engine.sv
// Bench for note_lane_engine: tick-count reference model checked every cycle,
// directed corner sequences, a pixel vector table and a randomized phase.
module tb_note_lane_engine;

  localparam int SH   = 480;
  localparam int NROW = 8;

  logic       clk, reset, tick, start, wr_en;
  logic [2:0] btn, wr_addr, wr_data;
  logic [9:0] pix_x, pix_y;
  logic [2:0] lane_on, lane_on_s, row, row_s;
  logic [9:0] pos, pos_s;
  logic [7:0] hits, misses;
  logic [1:0] hits_s, misses_s;
  logic [1:0] state, state_s;
  logic       done, done_s;

  note_lane_engine dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .btn(btn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pix_x(pix_x), .pix_y(pix_y), .lane_on(lane_on), .pos(pos), .row(row),
    .hits(hits), .misses(misses), .state(state), .done(done)
  );

  note_lane_engine #(.SCORE_W(2)) dut_s (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .btn(btn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pix_x(pix_x), .pix_y(pix_y), .lane_on(lane_on_s), .pos(pos_s), .row(row_s),
    .hits(hits_s), .misses(misses_s), .state(state_s), .done(done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: play progress is a tick count t; row = t/SH, pos = t%SH.
  logic [2:0] song [NROW];
  int m_state = 0;
  int m_t     = 0;
  int m_mask  = 0;
  int m_hits  = 0;
  int m_miss  = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] exp;
  } pix_vec_t;
  pix_vec_t pv [7];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    int  ppos, prow, plive, exp_lane;
    bit  play, win;
    @(posedge clk);
    play  = (m_state == 1);
    ppos  = m_t % SH;
    prow  = m_t / SH;
    plive = play ? (int'(song[prow]) & ~m_mask) : 0;
    exp_lane = 0;
    for (int i = 0; i < 3; i++)
      if (((plive >> i) & 1) == 1 && int'(pix_x) >= i * 220 && int'(pix_x) <= i * 220 + 199 &&
          int'(pix_y) + 10 >= ppos && int'(pix_y) <= ppos + 10)
        exp_lane |= (1 << i);
    if (!reset) begin
      m_state = 0; m_t = 0; m_mask = 0; m_hits = 0; m_miss = 0; exp_lane = 0;
    end else if (play) begin
      win = (ppos + 16 >= 400) && (ppos <= 416);
      for (int i = 0; i < 3; i++)
        if (btn[i]) begin
          if (win && ((plive >> i) & 1) == 1) begin
            m_hits++;
            m_mask |= (1 << i);
          end else begin
            m_miss++;
          end
        end
      if (tick) begin
        if (m_t + 1 == NROW * SH) m_state = 3;
        else begin
          m_t++;
          if (m_t % SH == 0) m_mask = 0;
        end
      end
    end else begin
      if (wr_en) song[wr_addr] = wr_data;
      if (start) begin
        m_state = 1; m_t = 0; m_mask = 0; m_hits = 0; m_miss = 0;
      end
    end
    #1;
    chk("state", int'(state), m_state);
    chk("pos", int'(pos), m_t % SH);
    chk("row", int'(row), m_t / SH);
    chk("hits", int'(hits), imin(m_hits, 255));
    chk("misses", int'(misses), imin(m_miss, 255));
    chk("done", int'(done), (m_state == 3) ? 1 : 0);
    chk("lane_on", int'(lane_on), exp_lane);
    chk("state_s", int'(state_s), m_state);
    chk("pos_s", int'(pos_s), m_t % SH);
    chk("row_s", int'(row_s), m_t / SH);
    chk("done_s", int'(done_s), (m_state == 3) ? 1 : 0);
    chk("hits_sat", int'(hits_s), imin(m_hits, 3));
    chk("misses_sat", int'(misses_s), imin(m_miss, 3));
    chk("lane_on_s", int'(lane_on_s), exp_lane);
    tick = 1'b0; start = 1'b0; btn = '0; wr_en = 1'b0; reset = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      cyc();
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [2:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int yy;
    pv[0] = '{10'd0,   10'd230, 3'b001};
    pv[1] = '{10'd210, 10'd240, 3'b000};
    pv[2] = '{10'd639, 10'd250, 3'b100};
    pv[3] = '{10'd440, 10'd251, 3'b000};
    pv[4] = '{10'd220, 10'd240, 3'b010};
    pv[5] = '{10'd419, 10'd229, 3'b000};
    pv[6] = '{10'd419, 10'd230, 3'b010};
    for (int i = 0; i < NROW; i++) song[i] = '0;

    tick = 0; start = 0; btn = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    pix_x = 0; pix_y = 0; reset = 1'b0;
    cyc();
    do_reset();
    chk("rst_state", int'(state), 0);
    chk("rst_pos", int'(pos), 0);
    chk("rst_hits", int'(hits), 0);
    chk("rst_lane_on", int'(lane_on), 0);
    chk("rst_done", int'(done), 0);
    for (int i = 0; i < NROW; i++) wr(3'(i), 3'($urandom));

    // Scroll and row advance through a full song
    wr(3'd0, 3'b101);
    wr(3'd1, 3'b010);
    go();
    pix_x = 10'd220; pix_y = 10'd5;
    ticks(SH);
    chk("adv_row", int'(row), 1);
    chk("adv_pos", int'(pos), 0);
    cyc();
    chk("adv_live", int'(lane_on), 3'b010);
    ticks(7 * SH);
    chk("end_done", int'(done), 1);
    chk("end_state", int'(state), 3);

    // Hit window edges
    wr(3'd0, 3'b001);
    go();
    ticks(383);
    btn = 3'b001; cyc();
    chk("win_early_miss", int'(misses), 1);
    ticks(1);
    pix_x = 10'd0; pix_y = 10'd384;
    btn = 3'b001; cyc();
    chk("win_edge_hit", int'(hits), 1);
    cyc();
    chk("win_lane_clear", int'(lane_on[0]), 0);
    ticks(6);
    btn = 3'b001; cyc();
    chk("win_repeat_miss", int'(misses), 2);

    // Simultaneous press with tick
    do_reset();
    wr(3'd0, 3'b111);
    go();
    ticks(400);
    btn = 3'b111; tick = 1'b1; cyc();
    chk("simul_hits", int'(hits), 3);
    chk("simul_pos", int'(pos), 401);

    // Reset mid-play
    do_reset();
    wr(3'd0, 3'b011);
    go();
    ticks(400);
    btn = 3'b011; cyc();
    ticks(80 + 123);
    chk("mid_pos", int'(pos), 123);
    chk("mid_hits", int'(hits), 2);
    pix_x = 10'd220; pix_y = 10'd123;
    do_reset();
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_pos", int'(pos), 0);
    chk("mid_rst_hits", int'(hits), 0);
    chk("mid_rst_lane_on", int'(lane_on), 0);

    // Pixel render table
    wr(3'd0, 3'b111);
    go();
    ticks(240);
    for (int k = 0; k < 7; k++) begin
      pix_x = pv[k].x; pix_y = pv[k].y;
      cyc();
      chk($sformatf("pix%0d", k), int'(lane_on), int'(pv[k].exp));
    end

    // Saturation and write lockout
    do_reset();
    wr(3'd0, 3'b111);
    wr(3'd1, 3'b011);
    go();
    ticks(384);
    btn = 3'b111; cyc();
    wr(3'd0, 3'b000);
    ticks(SH - 384);
    ticks(400);
    btn = 3'b011; cyc();
    chk("sat_hits_s", int'(hits_s), 3);
    chk("sat_hits", int'(hits), 5);
    ticks(NROW * SH - SH - 400);
    chk("sat_done", int'(done), 1);
    go();
    pix_x = 10'd0; pix_y = 10'd240;
    ticks(240);
    cyc();
    chk("lockout_row0", int'(lane_on), 3'b001);

    // Randomized phase
    do_reset();
    for (int i = 0; i < NROW; i++) wr(3'(i), 3'($urandom));
    go();
    for (int n = 0; n < 6000; n++) begin
      if ($urandom % 4000 == 0) begin
        reset = 1'b0;
      end else begin
        tick  = ($urandom % 4) != 0;
        start = ($urandom % 1500) == 0;
        for (int i = 0; i < 3; i++) btn[i] = ($urandom % 8) == 0;
        if (!start && ($urandom % 20) == 0) begin
          wr_en = 1'b1; wr_addr = 3'($urandom); wr_data = 3'($urandom);
        end
      end
      pix_x = 10'($urandom % 640);
      if ($urandom % 2 == 1) begin
        yy = (m_t % SH) + int'($urandom_range(0, 24)) - 12;
        if (yy < 0) yy = 0;
        pix_y = 10'(yy);
      end else begin
        pix_y = 10'($urandom % 480);
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
